// File: rtl/pulse_meter.sv
// Multi-channel gated pulse counter: synchronised inputs, back-to-back windows of gate_len cycles.
// Results load one edge after a window's last cycle; a result that is not accepted is overwritten and flagged.
module pulse_meter #(
  parameter int CHANNELS    = 4,
  parameter int CNT_WIDTH   = 16,
  parameter int GATE_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk_in,
  input  logic                          rst_in,
  input  logic                          enable_in,
  input  logic [GATE_WIDTH-1:0]         gate_len_in,
  input  logic [1:0]                    edge_mode_in,
  input  logic [CHANNELS-1:0]           pulse_in,
  output logic [CHANNELS*CNT_WIDTH-1:0] count_out,
  output logic [CHANNELS-1:0]           ovf_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic                          overrun_out
);

  // A single-flop synchroniser is never acceptable, so shallower settings are clamped to two.
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  localparam logic [1:0] MODE_RISE  = 2'b00;
  localparam logic [1:0] MODE_FALL  = 2'b01;
  localparam logic [1:0] MODE_BOTH  = 2'b10;
  localparam logic [1:0] MODE_LEVEL = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [SYNC_N-1:0][CHANNELS-1:0]    sync_q, sync_d;
  logic [CHANNELS-1:0]                hist_q, hist_d;
  logic [GATE_WIDTH-1:0]              gate_len_q, gate_len_d;
  logic [1:0]                         mode_q, mode_d;
  logic [GATE_WIDTH-1:0]              gate_cnt_q, gate_cnt_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CHANNELS-1:0]                wovf_q, wovf_d;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
  logic [CHANNELS-1:0]                res_ovf_q, res_ovf_d;
  logic                               valid_q, valid_d;
  logic                               overrun_q, overrun_d;

  logic [CHANNELS-1:0]                sync_val;
  logic [CHANNELS-1:0]                event_vec;
  logic [CHANNELS-1:0][CNT_WIDTH-1:0] cnt_next;
  logic [CHANNELS-1:0]                ovf_next;
  logic [GATE_WIDTH-1:0]              gate_last_idx;
  logic                               last_cycle;
  logic                               win_start;
  logic                               counting;
  logic                               load;
  logic                               accept;

  // State register
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable_in)  state_d = RUN;
      RUN:     if (!enable_in) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: window start, counting, and result load strobes
  always_comb begin
    win_start = 1'b0;
    counting  = 1'b0;
    load      = 1'b0;
    case (state_q)
      IDLE: begin
        win_start = enable_in;
      end
      RUN: begin
        if (enable_in) begin
          counting = 1'b1;
          if (last_cycle) begin
            load      = 1'b1;
            win_start = 1'b1;
          end
        end
      end
      default: begin
        win_start = 1'b0;
      end
    endcase
  end

  // Synchroniser chain; stage 0 samples the raw input.
  always_comb begin
    sync_d   = {sync_q[SYNC_N-2:0], pulse_in};
    sync_val = sync_q[SYNC_N-1];
    hist_d   = sync_val;
  end

  always_comb begin
    event_vec = '0;
    case (mode_q)
      MODE_RISE:  event_vec = sync_val & ~hist_q;
      MODE_FALL:  event_vec = ~sync_val & hist_q;
      MODE_BOTH:  event_vec = sync_val ^ hist_q;
      MODE_LEVEL: event_vec = sync_val;
      default:    event_vec = '0;
    endcase
  end

  // Overflow marks an event that arrived while the counter was already pinned at its maximum.
  always_comb begin
    cnt_next = cnt_q;
    ovf_next = wovf_q;
    for (int k = 0; k < CHANNELS; k++) begin
      if (event_vec[k]) begin
        if (cnt_q[k] == CNT_MAX) begin
          ovf_next[k] = 1'b1;
        end else begin
          cnt_next[k] = cnt_q[k] + CNT_WIDTH'(1);
        end
      end
    end
  end

  // A zero length behaves as a one-cycle window.
  always_comb begin
    gate_last_idx = (gate_len_q == '0) ? '0 : (gate_len_q - GATE_WIDTH'(1));
    last_cycle    = (gate_cnt_q == gate_last_idx);
  end

  always_comb begin
    gate_len_d = gate_len_q;
    mode_d     = mode_q;
    gate_cnt_d = '0;
    cnt_d      = '0;
    wovf_d     = '0;
    if (win_start) begin
      gate_len_d = gate_len_in;
      mode_d     = edge_mode_in;
    end else if (counting) begin
      gate_cnt_d = gate_cnt_q + GATE_WIDTH'(1);
      cnt_d      = cnt_next;
      wovf_d     = ovf_next;
    end
  end

  // Result holding register with valid/ready handshake and overrun tracking.
  always_comb begin
    accept    = valid_q & ready_in;
    res_cnt_d = load ? cnt_next : res_cnt_q;
    res_ovf_d = load ? ovf_next : res_ovf_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (load) begin
      valid_d = 1'b1;
    end else if (accept) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      overrun_d = 1'b0;
    end else if (load && valid_q) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sync_q     <= '0;
      hist_q     <= '0;
      gate_len_q <= '0;
      mode_q     <= '0;
      gate_cnt_q <= '0;
      cnt_q      <= '0;
      wovf_q     <= '0;
      res_cnt_q  <= '0;
      res_ovf_q  <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      hist_q     <= hist_d;
      gate_len_q <= gate_len_d;
      mode_q     <= mode_d;
      gate_cnt_q <= gate_cnt_d;
      cnt_q      <= cnt_d;
      wovf_q     <= wovf_d;
      res_cnt_q  <= res_cnt_d;
      res_ovf_q  <= res_ovf_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign count_out   = res_cnt_q;
  assign ovf_out     = res_ovf_q;
  assign valid_out   = valid_q;
  assign overrun_out = overrun_q;

endmodule

// File: tb/tb_pulse_meter.sv
// Directed bench for pulse_meter: a default-width instance and a 4-bit-counter instance share all inputs.
module tb_pulse_meter;

  logic        clk_in;
  logic        rst_in;
  logic        enable_in;
  logic [31:0] gate_len_in;
  logic [1:0]  edge_mode_in;
  logic [3:0]  pulse_in;
  logic        ready_in;

  logic [63:0] c16;
  logic [3:0]  ovf16;
  logic        valid16;
  logic        ovr16;
  logic [15:0] c4;
  logic [3:0]  ovf4;
  logic        valid4;
  logic        ovr4;

  int total;
  int passed;

  pulse_meter dut16 (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .enable_in    (enable_in),
    .gate_len_in  (gate_len_in),
    .edge_mode_in (edge_mode_in),
    .pulse_in     (pulse_in),
    .count_out    (c16),
    .ovf_out      (ovf16),
    .valid_out    (valid16),
    .ready_in     (ready_in),
    .overrun_out  (ovr16)
  );

  pulse_meter #(.CNT_WIDTH(4)) dut4 (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .enable_in    (enable_in),
    .gate_len_in  (gate_len_in),
    .edge_mode_in (edge_mode_in),
    .pulse_in     (pulse_in),
    .count_out    (c4),
    .ovf_out      (ovf4),
    .valid_out    (valid4),
    .ready_in     (ready_in),
    .overrun_out  (ovr4)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Enables a 40-cycle window, toggles ch2 seven times, and checks the loaded count.
  task automatic run_toggle(input logic [1:0] mode, input logic start_lvl, input logic [63:0] exp, input string tag);
    enable_in = 1'b0;
    pulse_in  = {1'b0, start_lvl, 2'b00};
    step(5);
    gate_len_in  = 32'd40;
    edge_mode_in = mode;
    enable_in    = 1'b1;
    step(3);
    for (int i = 0; i < 7; i++) begin
      pulse_in[2] = ~pulse_in[2];
      step(3);
    end
    step(17);
    chk({tag, "_valid"}, 64'(valid16), 64'd1);
    chk({tag, "_count"}, c16, exp);
  endtask

  initial begin
    total        = 0;
    passed       = 0;
    rst_in       = 1'b1;
    enable_in    = 1'b0;
    gate_len_in  = '0;
    edge_mode_in = 2'b00;
    pulse_in     = '0;
    ready_in     = 1'b1;
    step(3);
    chk("rst_count", c16, 64'd0);
    chk("rst_ovf", 64'(ovf16), 64'd0);
    chk("rst_valid", 64'(valid16), 64'd0);
    chk("rst_overrun", 64'(ovr16), 64'd0);
    chk("rst_count4", 64'(c4), 64'd0);

    // Rising edges, 100-cycle windows, 10 pulses on ch0
    rst_in       = 1'b0;
    gate_len_in  = 32'd100;
    edge_mode_in = 2'b00;
    enable_in    = 1'b1;
    step(5);
    for (int i = 0; i < 10; i++) begin
      pulse_in[0] = 1'b1;
      step(2);
      pulse_in[0] = 1'b0;
      step(3);
    end
    step(45);
    chk("w1_not_yet", 64'(valid16), 64'd0);
    step(1);
    chk("w1_valid", 64'(valid16), 64'd1);
    chk("w1_count", c16, 64'h0000_0000_0000_000a);
    chk("w1_ovf", 64'(ovf16), 64'd0);
    chk("w1_count4", 64'(c4), 64'h000a);
    step(1);
    chk("w1_accepted", 64'(valid16), 64'd0);
    chk("w1_hold", c16, 64'h0000_0000_0000_000a);
    step(98);
    chk("w2_not_yet", 64'(valid16), 64'd0);
    step(1);
    chk("w2_valid", 64'(valid16), 64'd1);
    chk("w2_count", c16, 64'd0);

    // Level mode, ch1 held high for a 50-cycle window
    enable_in = 1'b0;
    step(1);
    gate_len_in  = 32'd50;
    edge_mode_in = 2'b11;
    pulse_in     = 4'b0010;
    step(5);
    enable_in = 1'b1;
    step(50);
    chk("lvl_not_yet", 64'(valid16), 64'd0);
    step(1);
    chk("lvl_valid", 64'(valid16), 64'd1);
    chk("lvl_count16", c16, 64'h0000_0000_0032_0000);
    chk("lvl_ovf16", 64'(ovf16), 64'd0);
    chk("lvl_count4", 64'(c4), 64'h00f0);
    chk("lvl_ovf4", 64'(ovf4), 64'b0010);
    chk("lvl_valid4", 64'(valid4), 64'd1);

    // Edge-type selection on seven ch2 toggles
    run_toggle(2'b10, 1'b0, 64'h0000_0007_0000_0000, "both");
    run_toggle(2'b01, 1'b0, 64'h0000_0003_0000_0000, "fall_lo");
    run_toggle(2'b01, 1'b1, 64'h0000_0004_0000_0000, "fall_hi");

    // Overrun with 10-cycle windows
    enable_in = 1'b0;
    pulse_in  = '0;
    step(5);
    chk("ovr_pre_valid", 64'(valid16), 64'd0);
    ready_in     = 1'b0;
    gate_len_in  = 32'd10;
    edge_mode_in = 2'b00;
    enable_in    = 1'b1;
    step(11);
    chk("ovr_w1_valid", 64'(valid16), 64'd1);
    chk("ovr_w1_flag", 64'(ovr16), 64'd0);
    step(1);
    pulse_in[3] = 1'b1;
    step(2);
    pulse_in[3] = 1'b0;
    step(7);
    chk("ovr_w2_valid", 64'(valid16), 64'd1);
    chk("ovr_w2_flag", 64'(ovr16), 64'd1);
    chk("ovr_w2_count", c16, 64'h0001_0000_0000_0000);
    ready_in = 1'b1;
    step(1);
    ready_in = 1'b0;
    chk("acc_valid", 64'(valid16), 64'd0);
    chk("acc_flag", 64'(ovr16), 64'd0);
    chk("acc_hold", c16, 64'h0001_0000_0000_0000);
    step(9);
    chk("w3_valid", 64'(valid16), 64'd1);
    chk("w3_flag", 64'(ovr16), 64'd0);
    step(9);
    ready_in = 1'b1;
    step(1);
    chk("accload_valid", 64'(valid16), 64'd1);
    chk("accload_flag", 64'(ovr16), 64'd0);

    // Zero gate length: one result per cycle
    enable_in = 1'b0;
    pulse_in  = 4'b0001;
    step(5);
    gate_len_in  = 32'd0;
    edge_mode_in = 2'b11;
    enable_in    = 1'b1;
    step(1);
    chk("g0_first", 64'(valid16), 64'd0);
    step(1);
    chk("g0_valid1", 64'(valid16), 64'd1);
    chk("g0_count1", c16, 64'd1);
    step(1);
    chk("g0_valid2", 64'(valid16), 64'd1);
    chk("g0_count2", c16, 64'd1);
    chk("g0_flag", 64'(ovr16), 64'd0);

    // Enable dropped at cycle 40 of 100: partial window discarded
    enable_in = 1'b0;
    step(5);
    ready_in    = 1'b0;
    gate_len_in = 32'd100;
    enable_in   = 1'b1;
    step(40);
    enable_in = 1'b0;
    step(70);
    chk("drop_valid", 64'(valid16), 64'd0);
    chk("drop_hold", c16, 64'd1);

    // Reset mid-window, then ch0 held high through reset release
    gate_len_in = 32'd10;
    enable_in   = 1'b1;
    step(11);
    chk("prer_valid", 64'(valid16), 64'd1);
    chk("prer_count", c16, 64'd10);
    step(10);
    chk("prer_flag", 64'(ovr16), 64'd1);
    step(4);
    rst_in = 1'b1;
    step(1);
    chk("mid_rst_count", c16, 64'd0);
    chk("mid_rst_ovf4", 64'(ovf4), 64'd0);
    chk("mid_rst_valid", 64'(valid16), 64'd0);
    chk("mid_rst_flag", 64'(ovr16), 64'd0);
    chk("mid_rst_count4", 64'(c4), 64'd0);
    rst_in       = 1'b0;
    edge_mode_in = 2'b00;
    step(10);
    chk("post_rst_not_yet", 64'(valid16), 64'd0);
    step(1);
    chk("post_rst_valid", 64'(valid16), 64'd1);
    chk("post_rst_rise", c16, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
